// File: rtl/pic_rom_arbiter.sv
// Picture ROM arbiter: fixed-priority display port, starvation-guarded scanner port,
// owner-tagged read pipeline that returns ROM data to the port that issued the read.
`timescale 1ns/1ps
module pic_rom_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              starve_hit
);

    typedef enum logic { OWN_DISP = 1'b0, OWN_SCAN = 1'b1 } owner_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]        scnt_q, scnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]  tag_v_q, tag_v_d;
    owner_e            tag_own_q [ROM_LAT+1];
    owner_e            tag_own_d [ROM_LAT+1];
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              starve, accept;
    owner_e            winner;

    // Preemption only when the scanner is still asking with a full counter.
    always_comb begin
        starve = req1 && (scnt_q == STARVE_LIM);
        gnt0   = req0 && !starve;
        gnt1   = req1 && (!req0 || starve);
        accept = gnt0 || gnt1;
        winner = gnt1 ? OWN_SCAN : OWN_DISP;
    end

    always_comb begin
        scnt_d = '0;
        if (req1 && !gnt1) begin
            scnt_d = (scnt_q >= STARVE_LIM) ? STARVE_LIM : scnt_q + 8'd1;
        end

        rom_addr_d = rom_addr_q;
        if (gnt1) begin
            rom_addr_d = addr1;
        end else if (gnt0) begin
            rom_addr_d = addr0;
        end

        // Oldest tag lines up with rom_dout for the address issued ROM_LAT edges earlier.
        tag_v_d      = {tag_v_q[ROM_LAT-1:0], accept};
        tag_own_d[0] = winner;
        for (int unsigned i = 1; i <= ROM_LAT; i++) begin
            tag_own_d[i] = tag_own_q[i-1];
        end

        rvalid0_d = tag_v_q[ROM_LAT] && (tag_own_q[ROM_LAT] == OWN_DISP);
        rvalid1_d = tag_v_q[ROM_LAT] && (tag_own_q[ROM_LAT] == OWN_SCAN);
        rdata0_d  = rvalid0_d ? rom_dout : rdata0_q;
        rdata1_d  = rvalid1_d ? rom_dout : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q     <= '0;
            rom_addr_q <= '0;
            tag_v_q    <= '0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                tag_own_q[i] <= OWN_DISP;
            end
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            scnt_q     <= scnt_d;
            rom_addr_q <= rom_addr_d;
            tag_v_q    <= tag_v_d;
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                tag_own_q[i] <= tag_own_d[i];
            end
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign starve_hit = starve;

endmodule

// File: doc/pic_rom_arbiter.md
# pic_rom_arbiter

Shares the single synchronous picture ROM between two requesters: the display pixel fetch (port 0) and the square-search scanner (port 1). It replaces the free-running address mux with a request/grant scheduler. Port 0 has fixed priority and port 1 has a starvation guard. Each read is tagged with its owner, and the ROM data is routed back to the port that issued it. The block sits between the VGA timing/sprite logic, the square-detection logic and the ROM instance.

## Interface
Parameters:
- ADDR_W, 16, ROM address width
- DATA_W, 8, ROM data width
- ROM_LAT, 1, ROM read latency in clk edges from rom_addr change to rom_dout valid (1..4)
- STARVE_MAX, 15, consecutive denied cycles after which port 1 preempts port 0 (1..255)

Ports:
- clk  in  1  single clock for all logic; the ROM runs on the same clock
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  display read request
- addr0  in  ADDR_W  display read address
- gnt0  out  1  display request accepted this cycle (combinational)
- rvalid0  out  1  one-cycle pulse: rdata0 holds port-0 read data
- rdata0  out  DATA_W  port-0 read data
- req1  in  1  scanner read request
- addr1  in  ADDR_W  scanner read address
- gnt1  out  1  scanner request accepted this cycle (combinational)
- rvalid1  out  1  one-cycle pulse: rdata1 holds port-1 read data
- rdata1  out  DATA_W  port-1 read data
- rom_addr  out  ADDR_W  registered ROM address
- rom_dout  in  DATA_W  ROM read data
- starve_hit  out  1  one-cycle pulse when port 1 preempts port 0

## Operation
- Arbitration is evaluated every cycle. Default winner: port 0 if req0=1, else port 1 if req1=1, else none.
- Starvation counter `scnt` (8 bit):
  - increments on every cycle where req1=1 and gnt1=0;
  - clears on any cycle where gnt1=1 or req1=0;
  - saturates at STARVE_MAX.
- When scnt==STARVE_MAX and req1=1, port 1 wins over port 0. gnt0=0, gnt1=1 and starve_hit=1 that cycle.
- gnt0 and gnt1 are never high together. A gnt is never high without its req.
- A request is accepted at a clock edge where req and gnt are both high. A requester holds req and addr until it sees gnt. An accepted read cannot be cancelled.
- On acceptance, rom_addr <= winning addr. With no grant, rom_addr holds its value.
- Tag pipeline: a shift register of ROM_LAT+1 entries, each {valid, owner}. The acceptance edge loads {1, winner}; otherwise it loads {0, x}.
- When the oldest tag entry is valid, at the next edge:
  - rdata<owner> <= rom_dout;
  - rvalid<owner> pulses for one cycle;
  - the other port's rdata is unchanged.
- Back-to-back grants are allowed every cycle, to either port. Throughput is 1 read per cycle total.
- rdata0/rdata1 hold their last value between pulses.

## Timing
- Reset (async assert, sync-released by the system) forces these values: rom_addr=0, rdata0=rdata1=0, rvalid0=rvalid1=0, starve_hit=0, scnt=0, all tag entries invalid.
  - gnt0/gnt1 follow req combinationally. They may be high during reset, but nothing is accepted while rst_n=0.
- Read latency: a request accepted at edge t gives rvalid high in the cycle after edge t+ROM_LAT+1. For ROM_LAT=1 that is 2 cycles after acceptance.
- Return order equals acceptance order, per port and globally.
- Reset mid-operation drops all in-flight reads: no rvalid is produced for them after release.
- Simultaneous req0 and req1 with scnt<STARVE_MAX: port 0 is granted and scnt increments.
- If scnt has reached STARVE_MAX and req1 then drops, scnt clears and no preemption occurs.

## Test plan
- Reset check: assert rst_n=0 mid-stream with 2 reads in flight. All outputs must go to their reset values immediately, and no rvalid may appear for 4 cycles after release.
- Single port-0 read: ROM model returns addr[7:0]. Set req0=1, addr0=16'h1234 for one cycle. Required: gnt0=1, rom_addr=1234 next cycle, rvalid0 pulse 2 cycles after acceptance with rdata0=8'h34, and rvalid1 stays 0.
- Interleave: alternate req0/req1 grants every cycle with addr0=n and addr1=100+n for n=0..7. Required: 16 returns in acceptance order, each on the correct port with matching data.
- Starvation: hold req0=1 and req1=1 continuously with STARVE_MAX=15. Required: gnt1 and starve_hit on the 16th cycle, then port 0 for the next 15 cycles, repeating. Port 1 gets exactly 1 grant per 16 cycles.
- Idle hold: no requests for 10 cycles after a grant to 16'h00FF. Required: rom_addr stays 00FF and no rvalid pulses occur.
- Latency sweep: repeat the single-read test with ROM_LAT=1..4. Required: rvalid arrives ROM_LAT+1 cycles after acceptance with correct data.
